pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage LC-3b core: per-stage advance/squash strobes, PC enable and
// redirect sequencing. Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        icache_resp,
  input  logic        dmem_req,
  input  logic        dcache_resp,
  input  logic        idex_mem_read,
  input  logic [2:0]  idex_dest,
  input  logic [2:0]  id_src1,
  input  logic [2:0]  id_src2,
  input  logic        id_use1,
  input  logic        id_use2,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        pc_load,
  output logic        pc_sel,
  output logic [15:0] redirect_pc,
  output logic        ifid_load,
  output logic        idex_load,
  output logic        exme_load,
  output logic        mewb_load,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exme_flush,
  output logic        mewb_flush,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    StRun      = 2'b00,
    StMemWait  = 2'b01,
    StDrain    = 2'b10,
    StRedirect = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] redirect_q, redirect_d;
  logic        mem_stall, load_use, fetch_stall;

  assign mem_stall   = dmem_req & ~dcache_resp;
  assign load_use    = idex_mem_read & ((id_use1 & (id_src1 == idex_dest)) |
                                        (id_use2 & (id_src2 == idex_dest)));
  assign fetch_stall = ~icache_resp;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StRun;
      redirect_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      redirect_q <= redirect_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    redirect_d  = redirect_q;
    redirect_pc = redirect_q;
    pc_load     = 1'b1;
    pc_sel      = 1'b0;
    ifid_load   = 1'b1;
    idex_load   = 1'b1;
    exme_load   = 1'b1;
    mewb_load   = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exme_flush  = 1'b0;
    mewb_flush  = 1'b0;

    if (!reset) begin
      pc_load    = 1'b0;
      ifid_load  = 1'b0;
      idex_load  = 1'b0;
      exme_load  = 1'b0;
      mewb_load  = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exme_flush = 1'b1;
      mewb_flush = 1'b1;
    end else if (mem_stall) begin
      // Freeze everything up to EX/MEM; MEM/WB takes a bubble. DRAIN/REDIRECT hold their state.
      pc_load    = 1'b0;
      ifid_load  = 1'b0;
      idex_load  = 1'b0;
      exme_load  = 1'b0;
      mewb_flush = 1'b1;
      if (state_q == StRun || state_q == StMemWait) begin
        state_d = StMemWait;
      end
    end else begin
      unique case (state_q)
        StRun, StMemWait: begin
          state_d = StRun;
          if (br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            exme_flush = 1'b1;
            if (fetch_stall) begin
              // Wrong-path fetch still outstanding: park the target until it returns.
              pc_load    = 1'b0;
              redirect_d = br_target;
              state_d    = StDrain;
            end else begin
              pc_sel      = 1'b1;
              redirect_pc = br_target;
            end
          end else if (load_use) begin
            pc_load    = 1'b0;
            ifid_load  = 1'b0;
            idex_flush = 1'b1;
          end else if (fetch_stall) begin
            pc_load    = 1'b0;
            ifid_flush = 1'b1;
          end
        end
        StDrain: begin
          pc_load    = 1'b0;
          ifid_flush = 1'b1;
          if (icache_resp) begin
            state_d = StRedirect;
          end
        end
        StRedirect: begin
          pc_sel     = 1'b1;
          ifid_flush = 1'b1;
          state_d    = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  assign state = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        br_accept;

  assign br_accept = reset & ~mem_stall & br_taken &
                     ((state_q == StRun) | (state_q == StMemWait));

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      if (!pc_load && state_q != StRedirect && stall_cnt_q != 16'hffff) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (br_accept && flush_cnt_q != 16'hffff) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic, all checked against
// a cycle-level behavioural model of the control rules.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        icache_resp, dmem_req, dcache_resp, idex_mem_read;
  logic [2:0]  idex_dest, id_src1, id_src2;
  logic        id_use1, id_use2, br_taken;
  logic [15:0] br_target;
  logic        pc_load, pc_sel;
  logic [15:0] redirect_pc;
  logic        ifid_load, idex_load, exme_load, mewb_load;
  logic        ifid_flush, idex_flush, exme_flush, mewb_flush;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .icache_resp  (icache_resp),
    .dmem_req     (dmem_req),
    .dcache_resp  (dcache_resp),
    .idex_mem_read(idex_mem_read),
    .idex_dest    (idex_dest),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_use1      (id_use1),
    .id_use2      (id_use2),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .pc_load      (pc_load),
    .pc_sel       (pc_sel),
    .redirect_pc  (redirect_pc),
    .ifid_load    (ifid_load),
    .idex_load    (idex_load),
    .exme_load    (exme_load),
    .mewb_load    (mewb_load),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exme_flush   (exme_flush),
    .mewb_flush   (mewb_flush),
    .state        (state),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  typedef struct {
    bit        rst_n;
    bit        icr;
    bit        dreq;
    bit        dresp;
    bit        mrd;
    bit [2:0]  dest;
    bit [2:0]  s1;
    bit [2:0]  s2;
    bit        u1;
    bit        u2;
    bit        br;
    bit [15:0] tgt;
  } stim_t;

  int errors = 0;
  int checks = 0;

  // Model: mode 0 running, 1 waiting on dcache, 2 discarding wrong-path fetch, 3 redirecting.
  int          m_mode  = 0;
  logic [15:0] m_rpc   = 16'h0000;
  int          m_stall = 0;
  int          m_flush = 0;

  logic [11:0] e_ctl;
  logic [15:0] e_rpc;
  logic [31:0] e_cnt;
  int          e_next;
  bit          e_accept, e_latch;

  function automatic stim_t idle();
    stim_t s;
    s = '{rst_n: 1'b1, icr: 1'b1, dreq: 1'b0, dresp: 1'b0, mrd: 1'b0, dest: 3'd0, s1: 3'd0,
          s2: 3'd0, u1: 1'b0, u2: 1'b0, br: 1'b0, tgt: 16'h0000};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    reset = s.rst_n; icache_resp = s.icr; dmem_req = s.dreq; dcache_resp = s.dresp;
    idex_mem_read = s.mrd; idex_dest = s.dest; id_src1 = s.s1; id_src2 = s.s2;
    id_use1 = s.u1; id_use2 = s.u2; br_taken = s.br; br_target = s.tgt;
  endtask

  task automatic model_eval();
    bit ms, lu, fs, pcl, pcs;
    bit [3:0] ld, fl;  // bit 3 = IF/ID ... bit 0 = MEM/WB
    ms = dmem_req && !dcache_resp;
    lu = idex_mem_read && ((id_use1 && id_src1 == idex_dest) || (id_use2 && id_src2 == idex_dest));
    fs = !icache_resp;
    pcl = 1; pcs = 0; ld = 4'hf; fl = 4'h0;
    e_rpc = m_rpc; e_next = m_mode; e_accept = 0; e_latch = 0;
    if (!reset) begin
      pcl = 0; ld = 4'h0; fl = 4'hf; e_next = 0;
    end else if (ms) begin
      pcl = 0; ld = 4'b0001; fl = 4'b0001;
      if (m_mode <= 1) e_next = 1;
    end else if (m_mode == 2) begin
      pcl = 0; fl = 4'b1000;
      if (icache_resp) e_next = 3;
    end else if (m_mode == 3) begin
      pcs = 1; fl = 4'b1000; e_next = 0;
    end else if (br_taken) begin
      e_accept = 1; fl = 4'b1110;
      if (fs) begin
        pcl = 0; e_latch = 1; e_next = 2;
      end else begin
        pcs = 1; e_rpc = br_target; e_next = 0;
      end
    end else begin
      e_next = 0;
      if (lu) begin
        pcl = 0; ld[3] = 0; fl[2] = 1;
      end else if (fs) begin
        pcl = 0; fl[3] = 1;
      end
    end
    e_ctl = {pcl, pcs, ld, fl, 2'(m_mode)};
`ifdef PIPE_CTRL_PERF_EN
    e_cnt = {16'(m_stall), 16'(m_flush)};
`else
    e_cnt = 32'h0;
`endif
  endtask

  task automatic model_commit();
    if (!reset) begin
      m_mode = 0; m_rpc = 16'h0000; m_stall = 0; m_flush = 0;
    end else begin
      if (e_latch) m_rpc = br_target;
      if (!e_ctl[11] && m_mode != 3 && m_stall < 65535) m_stall++;
      if (e_accept && m_flush < 65535) m_flush++;
      m_mode = e_next;
    end
  endtask

  function automatic logic [11:0] obs_ctl();
    return {pc_load, pc_sel, ifid_load, idex_load, exme_load, mewb_load,
            ifid_flush, idex_flush, exme_flush, mewb_flush, state};
  endfunction

  task automatic test_reset();
    stim_t q[$];
    stim_t s;
    s = idle(); s.rst_n = 0; s.br = 1; s.dreq = 1; q.push_back(s); q.push_back(s);
    q.push_back(idle()); q.push_back(idle());
    foreach (q[i]) begin
      apply(q[i]); #2; model_eval();
      checks++;
      if (obs_ctl() !== e_ctl) begin
        errors++; $display("FAIL reset[%0d] ctl got %b want %b", i, obs_ctl(), e_ctl);
      end
      checks++;
      if (redirect_pc !== e_rpc) begin
        errors++; $display("FAIL reset[%0d] redirect_pc got %h want %h", i, redirect_pc, e_rpc);
      end
      checks++;
      if ({stall_cnt, flush_cnt} !== e_cnt) begin
        errors++; $display("FAIL reset[%0d] counters got %h want %h", i, {stall_cnt, flush_cnt},
                           e_cnt);
      end
      @(posedge clk); model_commit(); #1;
    end
  endtask

  task automatic test_mem_stall();
    stim_t q[$];
    stim_t s;
    s = idle(); s.dreq = 1;
    repeat (4) q.push_back(s);
    s.dresp = 1; q.push_back(s); q.push_back(idle());
    foreach (q[i]) begin
      apply(q[i]); #2; model_eval();
      checks++;
      if (obs_ctl() !== e_ctl) begin
        errors++; $display("FAIL mem_stall[%0d] ctl got %b want %b", i, obs_ctl(), e_ctl);
      end
      checks++;
      if ({stall_cnt, flush_cnt} !== e_cnt) begin
        errors++; $display("FAIL mem_stall[%0d] counters got %h want %h", i,
                           {stall_cnt, flush_cnt}, e_cnt);
      end
      @(posedge clk); model_commit(); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t q[$];
    stim_t s;
    s = idle(); s.mrd = 1; s.dest = 3; s.s1 = 3; s.u1 = 1; q.push_back(s); q.push_back(idle());
    s = idle(); s.mrd = 1; s.dest = 5; s.s2 = 5; s.u2 = 1; s.s1 = 5; q.push_back(s);
    s.u2 = 0; q.push_back(s);  // operand not actually read: no hazard
    foreach (q[i]) begin
      apply(q[i]); #2; model_eval();
      checks++;
      if (obs_ctl() !== e_ctl) begin
        errors++; $display("FAIL load_use[%0d] ctl got %b want %b", i, obs_ctl(), e_ctl);
      end
      @(posedge clk); model_commit(); #1;
    end
  endtask

  task automatic test_branch_ready();
    stim_t q[$];
    stim_t s;
    s = idle(); s.br = 1; s.tgt = 16'h3000; q.push_back(s); q.push_back(idle());
    foreach (q[i]) begin
      apply(q[i]); #2; model_eval();
      checks++;
      if (obs_ctl() !== e_ctl) begin
        errors++; $display("FAIL br_ready[%0d] ctl got %b want %b", i, obs_ctl(), e_ctl);
      end
      checks++;
      if (redirect_pc !== e_rpc) begin
        errors++; $display("FAIL br_ready[%0d] redirect_pc got %h want %h", i, redirect_pc, e_rpc);
      end
      checks++;
      if ({stall_cnt, flush_cnt} !== e_cnt) begin
        errors++; $display("FAIL br_ready[%0d] counters got %h want %h", i,
                           {stall_cnt, flush_cnt}, e_cnt);
      end
      @(posedge clk); model_commit(); #1;
    end
  endtask

  task automatic test_branch_miss();
    stim_t q[$];
    stim_t s;
    s = idle(); s.br = 1; s.tgt = 16'h0400; s.icr = 0; q.push_back(s);
    s = idle(); s.icr = 0; s.br = 1; s.tgt = 16'hbeef; q.push_back(s);  // ignored while draining
    s = idle(); s.icr = 0; s.mrd = 1; s.u1 = 1; q.push_back(s);
    q.push_back(idle()); q.push_back(idle()); q.push_back(idle());
    foreach (q[i]) begin
      apply(q[i]); #2; model_eval();
      checks++;
      if (obs_ctl() !== e_ctl) begin
        errors++; $display("FAIL br_miss[%0d] ctl got %b want %b", i, obs_ctl(), e_ctl);
      end
      checks++;
      if (redirect_pc !== e_rpc) begin
        errors++; $display("FAIL br_miss[%0d] redirect_pc got %h want %h", i, redirect_pc, e_rpc);
      end
      checks++;
      if ({stall_cnt, flush_cnt} !== e_cnt) begin
        errors++; $display("FAIL br_miss[%0d] counters got %h want %h", i,
                           {stall_cnt, flush_cnt}, e_cnt);
      end
      @(posedge clk); model_commit(); #1;
    end
  endtask

  task automatic test_stall_and_branch();
    stim_t q[$];
    stim_t s;
    s = idle(); s.br = 1; s.tgt = 16'h1234; s.dreq = 1;
    q.push_back(s); q.push_back(s);
    s.dresp = 1; q.push_back(s); q.push_back(idle());
    foreach (q[i]) begin
      apply(q[i]); #2; model_eval();
      checks++;
      if (obs_ctl() !== e_ctl) begin
        errors++; $display("FAIL stall_br[%0d] ctl got %b want %b", i, obs_ctl(), e_ctl);
      end
      checks++;
      if (redirect_pc !== e_rpc) begin
        errors++; $display("FAIL stall_br[%0d] redirect_pc got %h want %h", i, redirect_pc, e_rpc);
      end
      @(posedge clk); model_commit(); #1;
    end
  endtask

  task automatic test_random();
    stim_t s;
    for (int i = 0; i < 800; i++) begin
      s.rst_n = ($urandom_range(99) >= 2);
      s.icr   = ($urandom_range(99) < 65);
      s.dreq  = ($urandom_range(99) < 30);
      s.dresp = ($urandom_range(99) < 50);
      s.mrd   = ($urandom_range(99) < 35);
      s.dest  = 3'($urandom_range(3));
      s.s1    = 3'($urandom_range(3));
      s.s2    = 3'($urandom_range(3));
      s.u1    = 1'($urandom);
      s.u2    = 1'($urandom);
      s.br    = ($urandom_range(99) < 20);
      s.tgt   = 16'($urandom);
      apply(s); #2; model_eval();
      checks++;
      if (obs_ctl() !== e_ctl) begin
        errors++; $display("FAIL random[%0d] ctl got %b want %b", i, obs_ctl(), e_ctl);
      end
      checks++;
      if (redirect_pc !== e_rpc) begin
        errors++; $display("FAIL random[%0d] redirect_pc got %h want %h", i, redirect_pc, e_rpc);
      end
      checks++;
      if ({stall_cnt, flush_cnt} !== e_cnt) begin
        errors++; $display("FAIL random[%0d] counters got %h want %h", i,
                           {stall_cnt, flush_cnt}, e_cnt);
      end
      @(posedge clk); model_commit(); #1;
    end
  endtask

  initial begin
    stim_t s;
    s = idle(); s.rst_n = 0;
    apply(s);
    @(posedge clk); #1;  // settle registers out of X before checking begins
    test_reset();
    test_mem_stall();
    test_load_use();
    test_branch_ready();
    test_branch_miss();
    test_stall_and_branch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
